rc4_encryptor: RTL and testbench

- Single RC4 encryption engine that produces test ciphertext for the multi-core key-search decryptor array.
- Takes a 24-bit secret key and a plaintext message from a ROM, then runs initialisation, key scheduling (KSA) and keystream generation (PRGA) over an external 256x8 S RAM.
- Writes the ciphertext to a RAM that the decryptor cores can be loaded from.
- Sits beside the decryption top level as its counterpart: the encoder for the decoder.

---
 rtl/rc4_encryptor.sv | 186 ++++++++++++++++++
 tb/tb_rc4_encryptor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encryptor.sv
// RC4 encryption engine: builds S over an external 256x8 RAM, runs KSA with a 24-bit key,
// then XORs the PRGA keystream with plaintext ROM bytes and writes ciphertext RAM.
module rc4_encryptor #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [23:0]       secret_key,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [7:0]        pt_q,
    output logic [ADDR_W-1:0] ct_addr,
    output logic [7:0]        ct_data,
    output logic              ct_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] K_LAST = (ADDR_W + 1)'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        K_RD_I, K_WAIT_I, K_CALC, K_RD_J, K_WAIT_J, K_WR_I, K_WR_J,
        P_RD_I, P_WAIT_I, P_CALC_J, P_RD_J, P_WAIT_J, P_WR_I, P_WR_J,
        P_RD_F, P_WAIT_F, P_XOR
    } state_t;

    state_t          state;
    logic [23:0]     key;
    logic [7:0]      i;
    logic [7:0]      j;
    logic [ADDR_W:0] k;
    logic [1:0]      kmod;
    logic [7:0]      si;
    logic [7:0]      sj;
    logic [7:0]      key_byte;

    always_comb begin
        key_byte = key[23:16];
        case (kmod)
            2'd1:    key_byte = key[15:8];
            2'd2:    key_byte = key[7:0];
            default: key_byte = key[23:16];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            key     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            kmod    <= '0;
            si      <= '0;
            sj      <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wren  <= 1'b0;
            pt_addr <= '0;
            ct_addr <= '0;
            ct_data <= '0;
            ct_wren <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            s_wren  <= 1'b0;
            ct_wren <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    // done still high means the run just ended: a held start waits one cycle
                    if (start && !done) begin
                        key   <= secret_key;
                        i     <= '0;
                        j     <= '0;
                        kmod  <= '0;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    s_addr  <= i;
                    s_wdata <= i;
                    s_wren  <= 1'b1;
                    i       <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= '0;
                        state <= K_RD_I;
                    end
                end
                K_RD_I: begin
                    s_addr <= i;
                    state  <= K_WAIT_I;
                end
                K_WAIT_I: state <= K_CALC;
                K_CALC: begin
                    si    <= s_q;
                    j     <= j + s_q + key_byte;
                    state <= K_RD_J;
                end
                K_RD_J: begin
                    s_addr <= j;
                    state  <= K_WAIT_J;
                end
                K_WAIT_J: state <= K_WR_I;
                K_WR_I: begin
                    s_addr  <= i;
                    s_wdata <= s_q;
                    s_wren  <= 1'b1;
                    state   <= K_WR_J;
                end
                K_WR_J: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    s_wren  <= 1'b1;
                    i       <= i + 8'd1;
                    kmod    <= (kmod == 2'd2) ? 2'd0 : kmod + 2'd1;
                    if (i == 8'hFF) begin
                        j     <= '0;
                        k     <= '0;
                        state <= P_RD_I;
                    end else begin
                        state <= K_RD_I;
                    end
                end
                P_RD_I: begin
                    i      <= i + 8'd1;
                    s_addr <= i + 8'd1;
                    state  <= P_WAIT_I;
                end
                P_WAIT_I: state <= P_CALC_J;
                P_CALC_J: begin
                    si    <= s_q;
                    j     <= j + s_q;
                    state <= P_RD_J;
                end
                P_RD_J: begin
                    s_addr <= j;
                    state  <= P_WAIT_J;
                end
                P_WAIT_J: state <= P_WR_I;
                P_WR_I: begin
                    sj      <= s_q;
                    s_addr  <= i;
                    s_wdata <= s_q;
                    s_wren  <= 1'b1;
                    state   <= P_WR_J;
                end
                P_WR_J: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    s_wren  <= 1'b1;
                    state   <= P_RD_F;
                end
                P_RD_F: begin
                    s_addr  <= si + sj;
                    pt_addr <= k[ADDR_W-1:0];
                    state   <= P_WAIT_F;
                end
                P_WAIT_F: state <= P_XOR;
                P_XOR: begin
                    ct_addr <= k[ADDR_W-1:0];
                    ct_data <= s_q ^ pt_q;
                    ct_wren <= 1'b1;
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= P_RD_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Directed bench for rc4_encryptor: known RC4 vector, INIT contents, held start,
// mid-run reset and a one-byte message, with RAM/ROM models around two instances.
module tb_rc4_encryptor;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start = 1'b0, start1 = 1'b0;
    logic [23:0] secret_key = '0, secret_key1 = '0;
    logic        mem_clear = 1'b0;

    logic [7:0]        s_addr, s_wdata, s_q, pt_q, ct_data;
    logic [ADDR_W-1:0] pt_addr, ct_addr;
    logic              s_wren, ct_wren, busy, done;

    logic [7:0]        s_addr1, s_wdata1, s_q1, pt_q1, ct_data1;
    logic [ADDR_W-1:0] pt_addr1, ct_addr1;
    logic              s_wren1, ct_wren1, busy1, done1;

    rc4_encryptor #(.MSG_LEN(32), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
        .pt_addr(pt_addr), .pt_q(pt_q), .ct_addr(ct_addr), .ct_data(ct_data),
        .ct_wren(ct_wren), .busy(busy), .done(done)
    );

    rc4_encryptor #(.MSG_LEN(1), .ADDR_W(ADDR_W)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .secret_key(secret_key1),
        .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wren(s_wren1), .s_q(s_q1),
        .pt_addr(pt_addr1), .pt_q(pt_q1), .ct_addr(ct_addr1), .ct_data(ct_data1),
        .ct_wren(ct_wren1), .busy(busy1), .done(done1)
    );

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] s1_mem [256];
    logic [7:0] ct1_mem [256];
    logic [7:0] pt_rom [256];
    logic [7:0] exp_ct [256];
    logic [7:0] kv [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    int tests = 0, fails = 0;
    int done_cnt = 0, overlap_cnt = 0, idle_wren_cnt = 0;
    int done1_cnt = 0, ct1_wr_cnt = 0, ct1_bad_cnt = 0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]   <= 8'hEE;
                ct_mem[a]  <= 8'h00;
                s1_mem[a]  <= 8'hEE;
                ct1_mem[a] <= 8'h00;
            end
        end else begin
            if (s_wren)   s_mem[s_addr]     <= s_wdata;
            if (ct_wren)  ct_mem[ct_addr]   <= ct_data;
            if (s_wren1)  s1_mem[s_addr1]   <= s_wdata1;
            if (ct_wren1) ct1_mem[ct_addr1] <= ct_data1;
        end
        s_q   <= s_mem[s_addr];
        pt_q  <= pt_rom[pt_addr];
        s_q1  <= s1_mem[s_addr1];
        pt_q1 <= pt_rom[pt_addr1];
    end

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (done1) done1_cnt++;
        if ((s_wren && ct_wren) || (s_wren1 && ct_wren1)) overlap_cnt++;
        if ((s_wren && !busy) || (s_wren1 && !busy1)) idle_wren_cnt++;
        if (ct_wren1) begin
            ct1_wr_cnt++;
            if (ct_addr1 != 8'd0) ct1_bad_cnt++;
        end
    end

    // Reference RC4 over pt_rom (or over captured ciphertext, to decrypt) into exp_ct
    task automatic rc4_model(input logic [23:0] key, input int n, input bit from_ct);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i8, j8, t, f_idx, src;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j8 = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j8 = j8 + s[x] + kb[x % 3];
            t = s[x]; s[x] = s[j8]; s[j8] = t;
        end
        i8 = 8'd0;
        j8 = 8'd0;
        for (int x = 0; x < n; x++) begin
            i8 = i8 + 8'd1;
            j8 = j8 + s[i8];
            t = s[i8]; s[i8] = s[j8]; s[j8] = t;
            f_idx = s[i8] + s[j8];
            src = from_ct ? ct_mem[x] : pt_rom[x];
            exp_ct[x] = src ^ s[f_idx];
        end
    endtask

    task automatic clear_mems();
        @(negedge clk); mem_clear = 1'b1;
        @(negedge clk); mem_clear = 1'b0;
    endtask

    task automatic launch(input logic [23:0] key);
        @(negedge clk);
        secret_key = key;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: done got 0 within 4000 cycles, want 1", name);
        end
        @(negedge clk);
    endtask

    task automatic compare_model(input string name, input logic [23:0] key);
        int bad = 0;
        rc4_model(key, 32, 1'b0);
        for (int x = 0; x < 32; x++) if (ct_mem[x] !== exp_ct[x]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d ct bytes differ from model (ct[0] got %h want %h)",
                     name, bad, ct_mem[0], exp_ct[0]);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, s_wren, ct_wren} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, s_wren, ct_wren});
        end
        tests++;
        if ({s_addr, s_wdata} !== 16'h0) begin
            fails++; $display("FAIL reset_s_bus: got %h want 0000", {s_addr, s_wdata});
        end
        tests++;
        if ({pt_addr, ct_addr, ct_data} !== 24'h0) begin
            fails++; $display("FAIL reset_pt_ct: got %h want 000000", {pt_addr, ct_addr, ct_data});
        end
        tests++;
        if ({busy1, done1, s_wren1, ct_wren1} !== 4'b0) begin
            fails++; $display("FAIL reset_dut1: got %b want 0000", {busy1, done1, s_wren1, ct_wren1});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_known();
        int run = 0, bad = 0, d0;
        bit rose = 1'b0;
        clear_mems();
        d0 = done_cnt;
        launch(24'h4B6579);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise: got %b want 1", busy); end
        for (int c = 0; c < 10; c++) begin
            if (s_wren) begin rose = 1'b1; break; end
            @(negedge clk);
        end
        while (rose && s_wren && run < 300) begin run++; @(negedge clk); end
        tests++;
        if (run != 256) begin fails++; $display("FAIL init_wren_run: got %0d want 256", run); end
        for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL init_s: %0d entries differ, S[255] got %h want ff", bad, s_mem[255]); end
        wait_done("known_done");
        for (int x = 0; x < 9; x++) begin
            tests++;
            if (ct_mem[x] !== kv[x]) begin
                fails++; $display("FAIL known_ct[%0d]: got %h want %h", x, ct_mem[x], kv[x]);
            end
        end
        tests++;
        if ({busy, done} !== 2'b00) begin fails++; $display("FAIL known_after: busy,done got %b want 00", {busy, done}); end
        tests++;
        if (done_cnt - d0 != 1) begin fails++; $display("FAIL known_done_pulses: got %0d want 1", done_cnt - d0); end
        compare_model("known_model", 24'h4B6579);
    endtask

    task automatic test_key_zero();
        int bad = 0;
        clear_mems();
        launch(24'h000000);
        wait_done("zero_done");
        compare_model("zero_model", 24'h000000);
        rc4_model(24'h000000, 32, 1'b1);
        for (int x = 0; x < 32; x++) if (exp_ct[x] !== pt_rom[x]) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL zero_decrypt: %0d bytes differ, pt[0] got %h want %h", bad, exp_ct[0], pt_rom[0]); end
    endtask

    task automatic test_back_to_back();
        int d0;
        clear_mems();
        d0 = done_cnt;
        @(negedge clk);
        secret_key = 24'h0A1B2C;
        start = 1'b1;
        @(negedge clk);
        secret_key = 24'hC0FFEE;
        wait_done("b2b_done_a");
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap: busy got %b want 0", busy); end
        compare_model("b2b_model_a", 24'h0A1B2C);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart: busy got %b want 1", busy); end
        start = 1'b0;
        wait_done("b2b_done_b");
        compare_model("b2b_model_b", 24'hC0FFEE);
        tests++;
        if (done_cnt - d0 != 2) begin fails++; $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        clear_mems();
        launch(24'h112233);
        repeat (600) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, s_wren, ct_wren, done} !== 4'b0) begin
            fails++; $display("FAIL midrst_ctrl: got %b want 0000", {busy, s_wren, ct_wren, done});
        end
        tests++;
        if ({s_addr, s_wdata} !== 16'h0) begin fails++; $display("FAIL midrst_s_bus: got %h want 0000", {s_addr, s_wdata}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        launch(24'h4B6579);
        wait_done("midrst_done");
        for (int x = 0; x < 9; x++) begin
            tests++;
            if (ct_mem[x] !== kv[x]) begin
                fails++; $display("FAIL midrst_ct[%0d]: got %h want %h", x, ct_mem[x], kv[x]);
            end
        end
        tests++;
        if (done_cnt - d0 != 1) begin fails++; $display("FAIL midrst_done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_msg_len_one();
        int w0, b0, d0;
        bit seen = 1'b0;
        clear_mems();
        w0 = ct1_wr_cnt; b0 = ct1_bad_cnt; d0 = done1_cnt;
        @(negedge clk);
        secret_key1 = 24'h4B6579;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done1) begin seen = 1'b1; break; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL len1_done: got 0 within 4000 cycles, want 1"); end
        repeat (3) @(negedge clk);
        tests++;
        if (ct1_mem[0] !== 8'hBB) begin fails++; $display("FAIL len1_ct0: got %h want bb", ct1_mem[0]); end
        tests++;
        if (ct1_wr_cnt - w0 != 1) begin fails++; $display("FAIL len1_writes: got %0d want 1", ct1_wr_cnt - w0); end
        tests++;
        if (ct1_bad_cnt - b0 != 0) begin fails++; $display("FAIL len1_addr: got %0d stray writes want 0", ct1_bad_cnt - b0); end
        tests++;
        if (done1_cnt - d0 != 1 || busy1 !== 1'b0) begin
            fails++; $display("FAIL len1_end: pulses %0d busy %b want 1 0", done1_cnt - d0, busy1);
        end
    endtask

    task automatic test_bus_rules();
        tests++;
        if (overlap_cnt != 0) begin fails++; $display("FAIL wren_overlap: got %0d want 0", overlap_cnt); end
        tests++;
        if (idle_wren_cnt != 0) begin fails++; $display("FAIL idle_wren: got %0d want 0", idle_wren_cnt); end
    endtask

    initial begin
        pt_rom[0] = 8'h50; pt_rom[1] = 8'h6C; pt_rom[2] = 8'h61;
        pt_rom[3] = 8'h69; pt_rom[4] = 8'h6E; pt_rom[5] = 8'h74;
        pt_rom[6] = 8'h65; pt_rom[7] = 8'h78; pt_rom[8] = 8'h74;
        for (int x = 9; x < 256; x++) pt_rom[x] = 8'(x * 7 + 3);
        test_reset();
        test_init_known();
        test_key_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_msg_len_one();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
